// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter: round-robin, lockable arbiter sharing one ALU between the   |
// | fetch and execute stages. Optional macro: ALU_ARB_STARVE_GUARD_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_lock,
  input  logic [4:0]  req0_control,
  input  logic [31:0] req0_src_a,
  input  logic [31:0] req0_src_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_lock,
  input  logic [4:0]  req1_control,
  input  logic [31:0] req1_src_a,
  input  logic [31:0] req1_src_b,
  output logic [4:0]  alu_control,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  input  logic [31:0] alu_result,
  output logic        resp0_valid,
  output logic [31:0] resp0_result,
  output logic        resp1_valid,
  output logic [31:0] resp1_result,
  output logic        grant_owner
);

  localparam int                 c_cnt_w   = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(LOCK_MAX);
  localparam logic [4:0]         c_alu_add = 5'b00010;

  logic               last_q, last_d;
  logic               lock_active_q, lock_active_d;
  logic               lock_owner_q, lock_owner_d;
  logic [c_cnt_w-1:0] lock_cnt_q, lock_cnt_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic [31:0]        resp0_result_q, resp0_result_d;
  logic [31:0]        resp1_result_q, resp1_result_d;

  logic               lock_hold;
  logic               grant0, grant1, grant_any, grant_lock;
  logic [c_cnt_w-1:0] cnt_inc;

  // A lock only binds while its owner still presents an operation.
  always_comb begin
    lock_hold = lock_active_q && (lock_owner_q ? req1_valid : req0_valid);
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (lock_hold) begin
      grant0 = !lock_owner_q;
      grant1 = lock_owner_q;
    end else if (req0_valid && req1_valid) begin
      grant0 = last_q;
      grant1 = !last_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    grant_any  = grant0 || grant1;
    grant_lock = grant1 ? req1_lock : req0_lock;
  end

  always_comb begin
    alu_control = c_alu_add;
    alu_src_a   = 32'h0;
    alu_src_b   = 32'h0;
    if (grant0) begin
      alu_control = req0_control;
      alu_src_a   = req0_src_a;
      alu_src_b   = req0_src_b;
    end else if (grant1) begin
      alu_control = req1_control;
      alu_src_a   = req1_src_a;
      alu_src_b   = req1_src_b;
    end
  end

  always_comb begin
    cnt_inc        = (lock_cnt_q == c_cnt_max) ? lock_cnt_q : lock_cnt_q + c_cnt_w'(1);
    last_d         = grant_any ? grant1 : last_q;
    lock_active_d  = lock_active_q;
    lock_owner_d   = lock_owner_q;
    lock_cnt_d     = lock_cnt_q;
    resp0_valid_d  = grant0;
    resp1_valid_d  = grant1;
    resp0_result_d = grant0 ? alu_result : resp0_result_q;
    resp1_result_d = grant1 ? alu_result : resp1_result_q;
    if (grant_any) begin
      if (grant_lock) begin
`ifdef ALU_ARB_STARVE_GUARD_EN
        // Forced release once the owner has used its full budget.
        if (cnt_inc == c_cnt_max) begin
          lock_active_d = 1'b0;
          lock_cnt_d    = '0;
        end else begin
          lock_active_d = 1'b1;
          lock_owner_d  = grant1;
          lock_cnt_d    = cnt_inc;
        end
`else
        lock_active_d = 1'b1;
        lock_owner_d  = grant1;
        lock_cnt_d    = cnt_inc;
`endif
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = '0;
      end
    end else if (lock_active_q && !lock_hold) begin
      lock_active_d = 1'b0;
      lock_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q         <= 1'b1;
      lock_active_q  <= 1'b0;
      lock_owner_q   <= 1'b0;
      lock_cnt_q     <= '0;
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_result_q <= 32'h0;
      resp1_result_q <= 32'h0;
    end else begin
      last_q         <= last_d;
      lock_active_q  <= lock_active_d;
      lock_owner_q   <= lock_owner_d;
      lock_cnt_q     <= lock_cnt_d;
      resp0_valid_q  <= resp0_valid_d;
      resp1_valid_q  <= resp1_valid_d;
      resp0_result_q <= resp0_result_d;
      resp1_result_q <= resp1_result_d;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign resp0_valid  = resp0_valid_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp0_result = resp0_result_q;
  assign resp1_result = resp1_result_q;
  assign grant_owner  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Testbench for alu_arbiter: vector table plus hand sequences, scoreboarded responses.
module tb_alu_arbiter;

  localparam logic [4:0] ADD  = 5'b00010;
  localparam logic [4:0] SUB  = 5'b00110;
  localparam logic [4:0] XOR  = 5'b00011;
  localparam logic [4:0] LWRM = 5'b10101;
  localparam logic [4:0] LWR  = 5'b10010;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_lock;
  logic [4:0]  req0_control;
  logic [31:0] req0_src_a, req0_src_b;
  logic        req1_valid, req1_ready, req1_lock;
  logic [4:0]  req1_control;
  logic [31:0] req1_src_a, req1_src_b;
  logic [4:0]  alu_control;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic        resp0_valid, resp1_valid, grant_owner;
  logic [31:0] resp0_result, resp1_result;

  always #5 clk = ~clk;

  alu_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req0_control(req0_control), .req0_src_a(req0_src_a), .req0_src_b(req0_src_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .req1_control(req1_control), .req1_src_a(req1_src_a), .req1_src_b(req1_src_b),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result),
    .grant_owner(grant_owner)
  );

  // Behavioural ALU: LWR reads the previous-cycle result.
  function automatic logic [31:0] alu_fn(input logic [4:0] ctl, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] prev);
    case (ctl)
      ADD:     return a + b;
      SUB:     return a - b;
      XOR:     return a ^ b;
      LWRM:    return a + b;
      LWR:     return prev + a;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] alu_prev = 32'h0;
  always @(posedge clk) alu_prev <= alu_result;
  assign alu_result = alu_fn(alu_control, alu_src_a, alu_src_b, alu_prev);

  typedef struct {
    logic        v0, l0;
    logic [4:0]  c0;
    logic [31:0] a0, b0;
    logic        v1, l1;
    logic [4:0]  c1;
    logic [31:0] a1, b1;
    logic        r0, r1;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] exp_prev;
  int          passed, total;

  function automatic vec_t mk(input logic v0, input logic l0, input logic [4:0] c0,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic l1, input logic [4:0] c1,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.c0 = c0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.l1 = l1; v.c1 = c1; v.a1 = a1; v.b1 = b1;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " resp_valid"}, e.id ? resp1_valid : resp0_valid, 1);
      chk({tag, " other_resp_valid"}, e.id ? resp0_valid : resp1_valid, 0);
      chk({tag, " resp_result"}, e.id ? resp1_result : resp0_result, e.val);
      chk({tag, " grant_owner"}, grant_owner, e.id);
    end else begin
      chk({tag, " resp0_valid_idle"}, resp0_valid, 0);
      chk({tag, " resp1_valid_idle"}, resp1_valid, 0);
    end
  endtask

  task automatic run_cycle(input vec_t v, input string tag);
    exp_t        e;
    logic [31:0] m;
    req0_valid = v.v0; req0_lock = v.l0; req0_control = v.c0;
    req0_src_a = v.a0; req0_src_b = v.b0;
    req1_valid = v.v1; req1_lock = v.l1; req1_control = v.c1;
    req1_src_a = v.a1; req1_src_b = v.b1;
    @(negedge clk);
    check_resp(tag);
    chk({tag, " ready0"}, req0_ready, v.r0);
    chk({tag, " ready1"}, req1_ready, v.r1);
    if (v.r0 || v.r1) begin
      m = v.r0 ? alu_fn(v.c0, v.a0, v.b0, exp_prev) : alu_fn(v.c1, v.a1, v.b1, exp_prev);
      chk({tag, " alu_control"}, alu_control, v.r0 ? v.c0 : v.c1);
      chk({tag, " alu_src_a"}, alu_src_a, v.r0 ? v.a0 : v.a1);
      e.id  = v.r1;
      e.val = m;
      sb.push_back(e);
    end else begin
      m = 32'h0;
      chk({tag, " idle_control"}, alu_control, ADD);
      chk({tag, " idle_src_a"}, alu_src_a, 0);
      chk({tag, " idle_src_b"}, alu_src_b, 0);
    end
    exp_prev = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    passed = 0; total = 0; exp_prev = 32'h0;
    reset = 1'b1;
    req0_valid = 0; req0_lock = 0; req0_control = ADD; req0_src_a = 0; req0_src_b = 0;
    req1_valid = 0; req1_lock = 0; req1_control = ADD; req1_src_a = 0; req1_src_b = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset resp0_valid", resp0_valid, 0);
    chk("reset resp1_valid", resp1_valid, 0);
    chk("reset resp0_result", resp0_result, 0);
    chk("reset resp1_result", resp1_result, 0);
    chk("reset grant_owner", grant_owner, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // req0 alone, then idle
    vecs.push_back(mk(1, 0, ADD, 5, 7, 0, 0, ADD, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, ADD, 0, 0, 0, 0, ADD, 0, 0, 0, 0));
    // both valid, no lock: alternation (req0 was last granted)
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, ADD, 1, 1, 1, 0, XOR, 3, 5, i[0], !i[0]));
    // req1 locked LWR MEM then LWR; req0 stalled meanwhile
    vecs.push_back(mk(1, 0, ADD, 1, 1, 1, 1, LWRM, 8, 3, 0, 1));
    vecs.push_back(mk(1, 0, ADD, 1, 1, 1, 0, LWR, 32'h100, 0, 0, 1));
    vecs.push_back(mk(1, 0, ADD, 1, 1, 0, 0, ADD, 0, 0, 1, 0));
    // lock owner drops valid: other requester granted same cycle
    vecs.push_back(mk(1, 1, ADD, 2, 2, 0, 0, ADD, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, ADD, 0, 0, 1, 0, SUB, 9, 4, 0, 1));
    vecs.push_back(mk(1, 0, ADD, 3, 3, 1, 0, SUB, 9, 4, 1, 0));

    for (int i = 0; i < vecs.size(); i++)
      run_cycle(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a req1 lock
    run_cycle(mk(0, 0, ADD, 0, 0, 1, 1, ADD, 4, 4, 0, 1), "prelock");
    req0_valid = 1; req1_valid = 1; req1_lock = 1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    run_cycle(mk(1, 0, ADD, 6, 6, 1, 0, ADD, 7, 7, 1, 0), "postreset");

    // req1 holds lock continuously while req0 waits
    for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_STARVE_GUARD_EN
      v = mk(1, 0, ADD, 32'(i + 10), 1, 1, 1, ADD, 32'(i), 2, i == 4, i != 4);
`else
      v = mk(1, 0, ADD, 32'(i + 10), 1, 1, 1, ADD, 32'(i), 2, 0, 1);
`endif
      run_cycle(v, $sformatf("starve%0d", i));
    end

    run_cycle(mk(0, 0, ADD, 0, 0, 0, 0, ADD, 0, 0, 0, 0), "drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
